// File: rtl/sc_regarbiter_if.sv
// sc_regarbiter_if: requester/register bundle for the shared register arbiter.
// master = requester side, slave = arbiter side.
interface sc_regarbiter_if #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int NUM_REQ       = 4
);
  logic [NUM_REQ-1:0]               SC_REGARBITER_req_InBUS;
  logic [NUM_REQ-1:0]               SC_REGARBITER_op_InBUS;
  logic [NUM_REQ*DATAWIDTH_BUS-1:0] SC_REGARBITER_data_InBUS;
  logic [NUM_REQ-1:0]               SC_REGARBITER_grant_OutBUS;
  logic [NUM_REQ-1:0]               SC_REGARBITER_ack_OutBUS;
  logic                             SC_REGARBITER_clear_OutLow;
  logic                             SC_REGARBITER_load_OutLow;
  logic [DATAWIDTH_BUS-1:0]         SC_REGARBITER_data_OutBUS;
  logic                             SC_REGARBITER_busy_Out;

  modport master (
    output SC_REGARBITER_req_InBUS,
    output SC_REGARBITER_op_InBUS,
    output SC_REGARBITER_data_InBUS,
    input  SC_REGARBITER_grant_OutBUS,
    input  SC_REGARBITER_ack_OutBUS,
    input  SC_REGARBITER_clear_OutLow,
    input  SC_REGARBITER_load_OutLow,
    input  SC_REGARBITER_data_OutBUS,
    input  SC_REGARBITER_busy_Out
  );

  modport slave (
    input  SC_REGARBITER_req_InBUS,
    input  SC_REGARBITER_op_InBUS,
    input  SC_REGARBITER_data_InBUS,
    output SC_REGARBITER_grant_OutBUS,
    output SC_REGARBITER_ack_OutBUS,
    output SC_REGARBITER_clear_OutLow,
    output SC_REGARBITER_load_OutLow,
    output SC_REGARBITER_data_OutBUS,
    output SC_REGARBITER_busy_Out
  );
endinterface

// File: rtl/sc_regarbiter.sv
// sc_regarbiter: round-robin arbiter sharing one register among requesters.
// One single-cycle active-low strobe per granted request, 4-phase ack.
module sc_regarbiter #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int NUM_REQ       = 4
) (
  input  logic SC_REGARBITER_CLOCK_50,
  input  logic SC_REGARBITER_RESET_InLow,
  sc_regarbiter_if.slave bus
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE, GRANT, STROBE, ACK, WAIT_REL
  } state_t;

  state_t                   state;
  logic [IDXW-1:0]          win_idx;
  logic [IDXW-1:0]          last_idx;
  logic                     op_q;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       ack;
  logic                     clear_n;
  logic                     load_n;
  logic [DATAWIDTH_BUS-1:0] data_q;
  logic                     busy;

  logic                     found;
  logic [IDXW-1:0]          pick;
  int                       j;

  // Round-robin search starting just after the last served requester
  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(last_idx) + k) % NUM_REQ;
      if (!found && bus.SC_REGARBITER_req_InBUS[j]) begin
        found = 1'b1;
        pick  = IDXW'(j);
      end
    end
  end

  // Sequencer: latch winner, setup cycle, strobe, ack, wait for release
  always_ff @(posedge SC_REGARBITER_CLOCK_50 or negedge SC_REGARBITER_RESET_InLow) begin
    if (!SC_REGARBITER_RESET_InLow) begin
      state    <= IDLE;
      win_idx  <= '0;
      last_idx <= IDXW'(NUM_REQ - 1);
      op_q     <= 1'b0;
      grant    <= '0;
      ack      <= '0;
      clear_n  <= 1'b1;
      load_n   <= 1'b1;
      data_q   <= '0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            win_idx <= pick;
            op_q    <= bus.SC_REGARBITER_op_InBUS[pick];
            data_q  <= bus.SC_REGARBITER_data_InBUS[int'(pick)*DATAWIDTH_BUS +: DATAWIDTH_BUS];
            grant   <= ONE << pick;
            busy    <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (!bus.SC_REGARBITER_req_InBUS[win_idx]) begin
            grant <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            clear_n <= ~op_q;
            load_n  <= op_q;
            state   <= STROBE;
          end
        end
        STROBE: begin
          clear_n  <= 1'b1;
          load_n   <= 1'b1;
          ack      <= ONE << win_idx;
          last_idx <= win_idx;
          state    <= ACK;
        end
        ACK: begin
          ack   <= '0;
          state <= WAIT_REL;
        end
        WAIT_REL: begin
          if (!bus.SC_REGARBITER_req_InBUS[win_idx]) begin
            grant <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          grant   <= '0;
          ack     <= '0;
          clear_n <= 1'b1;
          load_n  <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.SC_REGARBITER_grant_OutBUS = grant;
  assign bus.SC_REGARBITER_ack_OutBUS   = ack;
  assign bus.SC_REGARBITER_clear_OutLow = clear_n;
  assign bus.SC_REGARBITER_load_OutLow  = load_n;
  assign bus.SC_REGARBITER_data_OutBUS  = data_q;
  assign bus.SC_REGARBITER_busy_Out     = busy;
endmodule

// File: tb/tb_sc_regarbiter.sv
// tb_sc_regarbiter: directed checks of the register arbiter.
// Covers load, clear, round-robin, abort, async reset and a 2x16 variant.
module tb_sc_regarbiter;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  sc_regarbiter_if #(.DATAWIDTH_BUS(8),  .NUM_REQ(4)) bus ();
  sc_regarbiter_if #(.DATAWIDTH_BUS(16), .NUM_REQ(2)) bus2 ();

  sc_regarbiter #(.DATAWIDTH_BUS(8), .NUM_REQ(4)) dut (
    .SC_REGARBITER_CLOCK_50    (clk),
    .SC_REGARBITER_RESET_InLow (rst_n),
    .bus                       (bus)
  );

  sc_regarbiter #(.DATAWIDTH_BUS(16), .NUM_REQ(2)) dut2 (
    .SC_REGARBITER_CLOCK_50    (clk),
    .SC_REGARBITER_RESET_InLow (rst_n),
    .bus                       (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [7:0] words [4];

  initial begin
    rst_n = 1'b0;
    bus.SC_REGARBITER_req_InBUS   = '0;
    bus.SC_REGARBITER_op_InBUS    = '0;
    bus.SC_REGARBITER_data_InBUS  = '0;
    bus2.SC_REGARBITER_req_InBUS  = '0;
    bus2.SC_REGARBITER_op_InBUS   = '0;
    bus2.SC_REGARBITER_data_InBUS = '0;
    words[0] = 8'h11; words[1] = 8'h22;
    words[2] = 8'h33; words[3] = 8'h44;
    repeat (2) tick();

    chk("rst_grant", 32'(bus.SC_REGARBITER_grant_OutBUS), 32'h0);
    chk("rst_ack",   32'(bus.SC_REGARBITER_ack_OutBUS),   32'h0);
    chk("rst_clear", 32'(bus.SC_REGARBITER_clear_OutLow), 32'h1);
    chk("rst_load",  32'(bus.SC_REGARBITER_load_OutLow),  32'h1);
    chk("rst_data",  32'(bus.SC_REGARBITER_data_OutBUS),  32'h0);
    chk("rst_busy",  32'(bus.SC_REGARBITER_busy_Out),     32'h0);
    rst_n = 1'b1;
    tick();

    // single load from requester 0
    bus.SC_REGARBITER_data_InBUS[0 +: 8] = 8'hA5;
    bus.SC_REGARBITER_req_InBUS = 4'b0001;
    tick();
    chk("ld_grant", 32'(bus.SC_REGARBITER_grant_OutBUS), 32'h1);
    chk("ld_busy",  32'(bus.SC_REGARBITER_busy_Out),     32'h1);
    chk("ld_data",  32'(bus.SC_REGARBITER_data_OutBUS),  32'hA5);
    chk("ld_setup", 32'(bus.SC_REGARBITER_load_OutLow),  32'h1);
    bus.SC_REGARBITER_data_InBUS[0 +: 8] = 8'hFF;
    tick();
    chk("ld_strobe", 32'(bus.SC_REGARBITER_load_OutLow),  32'h0);
    chk("ld_noclr",  32'(bus.SC_REGARBITER_clear_OutLow), 32'h1);
    chk("ld_noack",  32'(bus.SC_REGARBITER_ack_OutBUS),   32'h0);
    tick();
    chk("ld_ldhi",  32'(bus.SC_REGARBITER_load_OutLow), 32'h1);
    chk("ld_ack",   32'(bus.SC_REGARBITER_ack_OutBUS),  32'h1);
    tick();
    chk("ld_ackend", 32'(bus.SC_REGARBITER_ack_OutBUS),   32'h0);
    chk("ld_hold",   32'(bus.SC_REGARBITER_grant_OutBUS), 32'h1);
    bus.SC_REGARBITER_req_InBUS = 4'b0000;
    tick();
    chk("ld_rel",   32'(bus.SC_REGARBITER_grant_OutBUS), 32'h0);
    chk("ld_idle",  32'(bus.SC_REGARBITER_busy_Out),     32'h0);
    chk("ld_dhold", 32'(bus.SC_REGARBITER_data_OutBUS),  32'hA5);

    // clear from requester 2
    bus.SC_REGARBITER_data_InBUS[16 +: 8] = 8'h3C;
    bus.SC_REGARBITER_op_InBUS  = 4'b0100;
    bus.SC_REGARBITER_req_InBUS = 4'b0100;
    tick();
    chk("clr_grant", 32'(bus.SC_REGARBITER_grant_OutBUS), 32'h4);
    chk("clr_data",  32'(bus.SC_REGARBITER_data_OutBUS),  32'h3C);
    tick();
    chk("clr_strobe", 32'(bus.SC_REGARBITER_clear_OutLow), 32'h0);
    chk("clr_noload", 32'(bus.SC_REGARBITER_load_OutLow),  32'h1);
    tick();
    chk("clr_hi",  32'(bus.SC_REGARBITER_clear_OutLow), 32'h1);
    chk("clr_ack", 32'(bus.SC_REGARBITER_ack_OutBUS),   32'h4);
    tick();
    bus.SC_REGARBITER_req_InBUS = 4'b0000;
    bus.SC_REGARBITER_op_InBUS  = 4'b0000;
    tick();
    chk("clr_idle", 32'(bus.SC_REGARBITER_busy_Out), 32'h0);

    // round-robin with all four requesting
    do_reset();
    for (int i = 0; i < 4; i++) bus.SC_REGARBITER_data_InBUS[i*8 +: 8] = words[i];
    bus.SC_REGARBITER_req_InBUS = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      int w;
      w = i % 4;
      tick();
      chk("rr_grant", 32'(bus.SC_REGARBITER_grant_OutBUS), 32'(1) << w);
      chk("rr_data",  32'(bus.SC_REGARBITER_data_OutBUS),  32'(words[w]));
      tick();
      chk("rr_strobe", 32'(bus.SC_REGARBITER_load_OutLow), 32'h0);
      tick();
      chk("rr_ack", 32'(bus.SC_REGARBITER_ack_OutBUS), 32'(1) << w);
      tick();
      bus.SC_REGARBITER_req_InBUS[w] = 1'b0;
      tick();
      chk("rr_rel", 32'(bus.SC_REGARBITER_grant_OutBUS), 32'h0);
      bus.SC_REGARBITER_req_InBUS[w] = 1'b1;
    end
    bus.SC_REGARBITER_req_InBUS = 4'b0000;

    // abort: requester 1 drops during setup cycle
    do_reset();
    bus.SC_REGARBITER_req_InBUS = 4'b0010;
    tick();
    chk("ab_grant", 32'(bus.SC_REGARBITER_grant_OutBUS), 32'h2);
    bus.SC_REGARBITER_req_InBUS = 4'b0000;
    tick();
    chk("ab_rel",  32'(bus.SC_REGARBITER_grant_OutBUS), 32'h0);
    chk("ab_busy", 32'(bus.SC_REGARBITER_busy_Out),     32'h0);
    chk("ab_load", 32'(bus.SC_REGARBITER_load_OutLow),  32'h1);
    tick();
    chk("ab_noack", 32'(bus.SC_REGARBITER_ack_OutBUS),   32'h0);
    chk("ab_clr",   32'(bus.SC_REGARBITER_clear_OutLow), 32'h1);
    bus.SC_REGARBITER_req_InBUS = 4'b0011;
    tick();
    chk("ab_next", 32'(bus.SC_REGARBITER_grant_OutBUS), 32'h1);
    tick();
    tick();
    chk("ab_ack", 32'(bus.SC_REGARBITER_ack_OutBUS), 32'h1);
    bus.SC_REGARBITER_req_InBUS = 4'b0000;
    tick();
    tick();
    chk("ab_idle", 32'(bus.SC_REGARBITER_busy_Out), 32'h0);

    // async reset during strobe
    bus.SC_REGARBITER_data_InBUS[0 +: 8] = 8'h5A;
    bus.SC_REGARBITER_req_InBUS = 4'b0001;
    tick();
    tick();
    chk("ar_strobe", 32'(bus.SC_REGARBITER_load_OutLow), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_load",  32'(bus.SC_REGARBITER_load_OutLow),  32'h1);
    chk("ar_grant", 32'(bus.SC_REGARBITER_grant_OutBUS), 32'h0);
    chk("ar_busy",  32'(bus.SC_REGARBITER_busy_Out),     32'h0);
    chk("ar_data",  32'(bus.SC_REGARBITER_data_OutBUS),  32'h0);
    bus.SC_REGARBITER_req_InBUS = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();
    bus.SC_REGARBITER_data_InBUS[8 +: 8] = 8'h77;
    bus.SC_REGARBITER_req_InBUS = 4'b0010;
    tick();
    chk("ar_grant2", 32'(bus.SC_REGARBITER_grant_OutBUS), 32'h2);
    chk("ar_data2",  32'(bus.SC_REGARBITER_data_OutBUS),  32'h77);
    tick();
    chk("ar_strobe2", 32'(bus.SC_REGARBITER_load_OutLow), 32'h0);
    tick();
    chk("ar_ack2", 32'(bus.SC_REGARBITER_ack_OutBUS), 32'h2);
    bus.SC_REGARBITER_req_InBUS = 4'b0000;
    tick();
    tick();
    chk("ar_idle", 32'(bus.SC_REGARBITER_busy_Out), 32'h0);

    // two requesters, 16-bit data
    bus2.SC_REGARBITER_data_InBUS = {16'hBEEF, 16'h1234};
    bus2.SC_REGARBITER_req_InBUS  = 2'b11;
    tick();
    chk("p2_grant0", 32'(bus2.SC_REGARBITER_grant_OutBUS), 32'h1);
    chk("p2_data0",  32'(bus2.SC_REGARBITER_data_OutBUS),  32'h1234);
    tick();
    tick();
    chk("p2_ack0", 32'(bus2.SC_REGARBITER_ack_OutBUS), 32'h1);
    tick();
    bus2.SC_REGARBITER_req_InBUS = 2'b10;
    tick();
    chk("p2_rel0", 32'(bus2.SC_REGARBITER_grant_OutBUS), 32'h0);
    tick();
    chk("p2_grant1", 32'(bus2.SC_REGARBITER_grant_OutBUS), 32'h2);
    chk("p2_data1",  32'(bus2.SC_REGARBITER_data_OutBUS),  32'hBEEF);
    tick();
    chk("p2_strobe", 32'(bus2.SC_REGARBITER_load_OutLow), 32'h0);
    tick();
    chk("p2_ack1", 32'(bus2.SC_REGARBITER_ack_OutBUS), 32'h2);
    bus2.SC_REGARBITER_req_InBUS = 2'b00;
    tick();
    tick();
    chk("p2_idle", 32'(bus2.SC_REGARBITER_busy_Out), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
